// File: rtl/rv32i_instr_encoder.sv
// rtl/rv32i_instr_encoder.sv - RV32I instruction encoder with range checks and word-address tagging
// Optional: ENCODER_NOP_ON_ERR_EN emits NOP for errored entries instead of dropping them.
package rv32i_pkg;
    typedef enum logic [5:0] {
        INSTR_ILLEGAL, INSTR_LUI, INSTR_AUIPC, INSTR_JAL, INSTR_JALR,
        INSTR_BEQ, INSTR_BNE, INSTR_BLT, INSTR_BGE, INSTR_BLTU, INSTR_BGEU,
        INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU,
        INSTR_SB, INSTR_SH, INSTR_SW,
        INSTR_ADDI, INSTR_SLTI, INSTR_SLTIU, INSTR_XORI, INSTR_ORI, INSTR_ANDI,
        INSTR_SLLI, INSTR_SRLI, INSTR_SRAI,
        INSTR_ADD, INSTR_SUB, INSTR_SLL, INSTR_SLT, INSTR_SLTU,
        INSTR_XOR, INSTR_SRL, INSTR_SRA, INSTR_OR, INSTR_AND
    } rv32i_instr_e;
endpackage

module rv32i_instr_encoder
    import rv32i_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [5:0]            in_op,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [31:0]           in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  err,
    output logic [2:0]            err_code
);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [31:0]           NOP  = 32'h0000_0013;
`ifdef ENCODER_NOP_ON_ERR_EN
    localparam bit NOP_ON_ERR = 1'b1;
`else
    localparam bit NOP_ON_ERR = 1'b0;
`endif

    typedef enum logic [2:0] {FMT_BAD, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

    rv32i_instr_e      op;
    fmt_e              fmt;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [6:0]        opc;
    logic [31:0]       enc;
    logic [2:0]        chk;
    logic signed [31:0] simm;
    logic              in_hs;
    logic              out_hs;
    logic              wrap;

    assign op       = rv32i_instr_e'(in_op);
    assign simm     = in_imm;
    assign in_ready = !out_valid || out_ready;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;
    assign wrap     = out_hs && (out_addr == '1);

    always_comb begin
        fmt = FMT_BAD;
        f3  = 3'd0;
        f7  = 7'd0;
        opc = 7'd0;
        case (op)
            INSTR_LUI:   begin fmt = FMT_U; opc = 7'h37; end
            INSTR_AUIPC: begin fmt = FMT_U; opc = 7'h17; end
            INSTR_JAL:   begin fmt = FMT_J; opc = 7'h6F; end
            INSTR_JALR:  begin fmt = FMT_I; opc = 7'h67; end
            INSTR_BEQ:   begin fmt = FMT_B; opc = 7'h63; f3 = 3'd0; end
            INSTR_BNE:   begin fmt = FMT_B; opc = 7'h63; f3 = 3'd1; end
            INSTR_BLT:   begin fmt = FMT_B; opc = 7'h63; f3 = 3'd4; end
            INSTR_BGE:   begin fmt = FMT_B; opc = 7'h63; f3 = 3'd5; end
            INSTR_BLTU:  begin fmt = FMT_B; opc = 7'h63; f3 = 3'd6; end
            INSTR_BGEU:  begin fmt = FMT_B; opc = 7'h63; f3 = 3'd7; end
            INSTR_LB:    begin fmt = FMT_I; opc = 7'h03; f3 = 3'd0; end
            INSTR_LH:    begin fmt = FMT_I; opc = 7'h03; f3 = 3'd1; end
            INSTR_LW:    begin fmt = FMT_I; opc = 7'h03; f3 = 3'd2; end
            INSTR_LBU:   begin fmt = FMT_I; opc = 7'h03; f3 = 3'd4; end
            INSTR_LHU:   begin fmt = FMT_I; opc = 7'h03; f3 = 3'd5; end
            INSTR_SB:    begin fmt = FMT_S; opc = 7'h23; f3 = 3'd0; end
            INSTR_SH:    begin fmt = FMT_S; opc = 7'h23; f3 = 3'd1; end
            INSTR_SW:    begin fmt = FMT_S; opc = 7'h23; f3 = 3'd2; end
            INSTR_ADDI:  begin fmt = FMT_I; opc = 7'h13; f3 = 3'd0; end
            INSTR_SLTI:  begin fmt = FMT_I; opc = 7'h13; f3 = 3'd2; end
            INSTR_SLTIU: begin fmt = FMT_I; opc = 7'h13; f3 = 3'd3; end
            INSTR_XORI:  begin fmt = FMT_I; opc = 7'h13; f3 = 3'd4; end
            INSTR_ORI:   begin fmt = FMT_I; opc = 7'h13; f3 = 3'd6; end
            INSTR_ANDI:  begin fmt = FMT_I; opc = 7'h13; f3 = 3'd7; end
            INSTR_SLLI:  begin fmt = FMT_SH; opc = 7'h13; f3 = 3'd1; end
            INSTR_SRLI:  begin fmt = FMT_SH; opc = 7'h13; f3 = 3'd5; end
            INSTR_SRAI:  begin fmt = FMT_SH; opc = 7'h13; f3 = 3'd5; f7 = 7'h20; end
            INSTR_ADD:   begin fmt = FMT_R; opc = 7'h33; f3 = 3'd0; end
            INSTR_SUB:   begin fmt = FMT_R; opc = 7'h33; f3 = 3'd0; f7 = 7'h20; end
            INSTR_SLL:   begin fmt = FMT_R; opc = 7'h33; f3 = 3'd1; end
            INSTR_SLT:   begin fmt = FMT_R; opc = 7'h33; f3 = 3'd2; end
            INSTR_SLTU:  begin fmt = FMT_R; opc = 7'h33; f3 = 3'd3; end
            INSTR_XOR:   begin fmt = FMT_R; opc = 7'h33; f3 = 3'd4; end
            INSTR_SRL:   begin fmt = FMT_R; opc = 7'h33; f3 = 3'd5; end
            INSTR_SRA:   begin fmt = FMT_R; opc = 7'h33; f3 = 3'd5; f7 = 7'h20; end
            INSTR_OR:    begin fmt = FMT_R; opc = 7'h33; f3 = 3'd6; end
            INSTR_AND:   begin fmt = FMT_R; opc = 7'h33; f3 = 3'd7; end
            default:     fmt = FMT_BAD;
        endcase
    end

    always_comb begin
        enc = 32'd0;
        chk = 3'd0;
        case (fmt)
            FMT_R:  enc = {f7, in_rs2, in_rs1, f3, in_rd, opc};
            FMT_I:  enc = {in_imm[11:0], in_rs1, f3, in_rd, opc};
            FMT_SH: enc = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc};
            FMT_S:  enc = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
            FMT_B:  enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], opc};
            FMT_U:  enc = {in_imm[31:12], in_rd, opc};
            FMT_J:  enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
            default: enc = 32'd0;
        endcase
        // Checks in descending priority; the first failing one wins.
        if (fmt == FMT_BAD)
            chk = 3'd1;
        else if ((fmt == FMT_B || fmt == FMT_J) && in_imm[0])
            chk = 3'd3;
        else if (((fmt == FMT_I || fmt == FMT_S) && (simm < -2048 || simm > 2047)) ||
                 (fmt == FMT_SH && (simm < 0 || simm > 31)) ||
                 (fmt == FMT_B && (simm < -4096 || simm > 4094)) ||
                 (fmt == FMT_J && (simm < -1048576 || simm > 1048574)))
            chk = 3'd2;
        else if (fmt == FMT_U && in_imm[11:0] != 12'd0)
            chk = 3'd4;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            out_valid <= 1'b0;
            out_instr <= 32'd0;
            out_addr  <= BASE;
            err       <= 1'b0;
            err_code  <= 3'd0;
        end else begin
            // out_addr is the address of the presented word, or of the next one when idle.
            if (out_hs)
                out_addr <= out_addr + 1'b1;
            if (in_hs && (chk == 3'd0 || NOP_ON_ERR)) begin
                out_valid <= 1'b1;
                out_instr <= (chk == 3'd0) ? enc : NOP;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
            if (!err) begin
                if (wrap)
                    err_code <= 3'd5;
                else if (in_hs && chk != 3'd0)
                    err_code <= chk;
            end
            if (wrap || (in_hs && chk != 3'd0))
                err <= 1'b1;
        end
    end
endmodule

// File: doc/rv32i_instr_encoder.md
Name: rv32i_instr_encoder

Overview:
- Inverse of the instruction disassembler: takes a decoded instruction (rv32i_instr_e op, register indices, signed immediate) and packs it into a 32-bit RV32I machine word.
- Checks field ranges and tags each emitted word with a sequential instruction-memory word address.
- Sits between testbench/boot-loader program generators and the instruction-memory write port.
- Valid/ready on both sides; one-entry registered output stage.

Parameters:
- ADDR_WIDTH, 10: width of the word-address counter `out_addr`.
- BASE_ADDR, 0: word address of the first emitted instruction after reset or `clear`.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- clear  in  1  synchronous: flush output stage, counter to BASE_ADDR, clear error state.
- in_valid  in  1  input entry valid.
- in_ready  out  1  encoder can accept an entry.
- in_op  in  6  rv32i_instr_e opcode enum.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_imm  in  32  signed immediate. Branch/JAL: byte offset. Shifts: shamt. U-type: full 32-bit value.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  sink accepts the word.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_WIDTH  word address of `out_instr`.
- err  out  1  sticky error flag.
- err_code  out  3  code of the first error since reset/clear.

Behaviour:
- Reset (or clear): out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0, err_code=0. in_ready=1 in the cycle after.
- in_ready = !out_valid || out_ready (pass-through ready, no combinational path from in_valid).
- Accept on in_valid && in_ready at edge N. Result is registered: out_valid=1 after edge N, so latency is 1 cycle. Full throughput while out_ready=1.
- While out_valid && !out_ready: out_instr and out_addr held stable; in_ready=0.
- Address counter:
  - Increments on every output handshake (out_valid && out_ready), modulo 2^ADDR_WIDTH.
  - out_addr always shows the address of the currently presented word.
  - Wrap from all-ones to 0 still emits the word, and raises error code 5.
- Encoding rules:
  - Standard RV32I bit placement, opcode/funct3/funct7 per ISA.
  - Fields unused by the format are ignored (e.g. rs2 on I-type).
  - Shifts: funct7 0000000 (SLLI/SRLI) or 0100000 (SRAI); shamt = in_imm[4:0].
- Checks, highest priority first; only the highest-priority failing check is reported per entry:
  1. op == INSTR_ILLEGAL or op > INSTR_AND → code 1.
  2. B/J-type with in_imm[0]=1 → code 3 (misaligned).
  3. Out-of-range immediate → code 2. Allowed ranges:
     - I/S/load/JALR: −2048..2047.
     - Shifts: 0..31.
     - B-type: −4096..4094.
     - JAL: −1048576..1048574.
  4. U-type with in_imm[11:0]≠0 → code 4.
- On error:
  - Entry is consumed (handshake completes) and not emitted; the counter does not advance.
  - err is set and stays set.
  - err_code latches only if err was 0, so the first error wins.
- Simultaneous events:
  - clear with an input handshake: clear wins, entry discarded.
  - clear with an output handshake: word counts as delivered, state still cleared.
  - rst overrides clear.
- Reset mid-stream: pending output word is dropped without handshake.

Optional Feature:
- Macro: ENCODER_NOP_ON_ERR_EN.
- Defined: an errored entry is emitted as NOP 0x00000013 (addi x0,x0,0) at the next address and the counter advances, keeping addresses aligned with the source sequence. err/err_code are still set.
- Undefined: errored entries are dropped as described in Behaviour.

Test Plan:
- Reset, then addi x1,x0,5; lui x2,0x12345000; srai x5,x6,3 back-to-back with out_ready=1 → 0x00500093 @0, 0x12345137 @1, 0x40335293 @2. out_valid continuous, err=0.
- sub x3,x1,x2; beq x1,x2,−8; jal x1,2048 → 0x402081B3, 0xFE208CE3, 0x001000EF at consecutive addresses.
- addi imm=2048, then beq imm=3, then addi x1,x0,5 → first two dropped; err=1, err_code=2 (first error retained); next word 0x00500093 at the unadvanced address. With ENCODER_NOP_ON_ERR_EN → 0x00000013, 0x00000013, 0x00500093 at addresses 0,1,2.
- out_ready held low 3 cycles with a second entry valid → in_ready=0, out_instr/out_addr stable. Second entry accepted on the release cycle and emitted the following cycle.
- ADDR_WIDTH=2: emit 5 words → addresses 0,1,2,3,0; err_code=5 after the fifth handshake.
- Assert clear with in_valid=1 and out_valid=1, out_ready=0 → next cycle out_valid=0, out_addr=BASE_ADDR, err=0; input entry not emitted.
